// File: rtl/delay_pkg.sv
// Shared constants for the delay line controller slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package delay_pkg;

  // Tap address width for an SRL16E-based line (16 taps).
  localparam int DEFAULT_DELAY_BITS = 4;

  // Controller state encoding.
  typedef logic state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_SETTLE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a one-hot grant.
// Latency: grant is combinational from req; pointer updates on the grant edge.
// Backpressure: grant_en low suppresses every grant and freezes the pointer.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : request lines (bit n = requester n)
//   grant_en   : arbitration allowed this cycle
//   gnt[1:0]   : one-hot grant, zero when nothing is granted
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  // 1 = requester 1 was granted most recently, so requester 0 wins a tie.
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (grant_en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Tap-address controller for the SRL16E variable delay line, with valid tracking.
// Latency: ack/delay one cycle after grant; out_valid = in_valid delayed delay+1 cycles.
// Backpressure: while settling (busy) requests are held off and out_valid is blanked.
//
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   in_valid                 : qualifier for din entering the line this cycle
//   req0/req0_delay/ack0     : requester 0 handshake (req held until ack pulse)
//   req1/req1_delay/ack1     : requester 1 handshake (req held until ack pulse)
//   delay                    : registered tap address to the delay line
//   out_valid                : delay line dout is valid this cycle
//   busy                     : settling after a tap change, requests not taken
module delay_line_ctrl
  import delay_pkg::*;
#(
  parameter int DELAY_BITS  = DEFAULT_DELAY_BITS,
  parameter int RESET_DELAY = 0,
  parameter bit SETTLE_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  req0,
  input  logic [DELAY_BITS-1:0] req0_delay,
  output logic                  ack0,
  input  logic                  req1,
  input  logic [DELAY_BITS-1:0] req1_delay,
  output logic                  ack1,
  output logic [DELAY_BITS-1:0] delay,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int DEPTH = 2**DELAY_BITS;

  state_t                state_q;
  state_t                state_d;
  logic [DELAY_BITS-1:0] cnt_q;
  logic [DELAY_BITS-1:0] delay_q;
  logic [DEPTH-1:0]      vsr_q;
  logic                  ack0_q;
  logic                  ack1_q;

  logic [1:0]            gnt;
  logic                  grant_en;
  logic                  granted;
  logic [DELAY_BITS-1:0] new_delay;
  logic                  change;

  // Requests are only looked at while idle; pending ones simply wait out SETTLE.
  assign grant_en  = (state_q == ST_IDLE);
  assign granted   = |gnt;
  assign new_delay = gnt[1] ? req1_delay : req0_delay;
  // Rewriting the current tap needs no settle time.
  assign change    = granted && (new_delay != delay_q) && SETTLE_EN;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({req1, req0}),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (change) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: tap address, settle counter, ack pulses, valid shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q <= DELAY_BITS'(RESET_DELAY);
      cnt_q   <= '0;
      vsr_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      // Shifts in every state so alignment survives the settle window.
      vsr_q  <= {vsr_q[DEPTH-2:0], in_valid};
      ack0_q <= gnt[0];
      ack1_q <= gnt[1];
      if (granted) begin
        delay_q <= new_delay;
      end
      // Loading the new tap value gives new_delay+1 settle cycles (counts down to 0).
      if (change) begin
        cnt_q <= new_delay;
      end else if ((state_q == ST_SETTLE) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Outputs.
  always_comb begin
    busy      = (state_q == ST_SETTLE);
    out_valid = vsr_q[delay_q] && (state_q == ST_IDLE);
    delay     = delay_q;
    ack0      = ack0_q;
    ack1      = ack1_q;
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
module tb_delay_line_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       req0;
  logic [3:0] req0_delay;
  logic       ack0;
  logic       req1;
  logic [3:0] req1_delay;
  logic       ack1;
  logic [3:0] delay;
  logic       out_valid;
  logic       busy;

  always #5 clk = ~clk;

  delay_line_ctrl #(
    .DELAY_BITS  (4),
    .RESET_DELAY (0),
    .SETTLE_EN   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .req0       (req0),
    .req0_delay (req0_delay),
    .ack0       (ack0),
    .req1       (req1),
    .req1_delay (req1_delay),
    .ack1       (ack1),
    .delay      (delay),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: in_valid history by edge number, current tap, the last
  // edge whose following cycle is still blanked, and the round-robin winner.
  int  cyc = 0;
  bit  vin [0:8191];
  int  m_delay;
  int  m_busy_last;
  int  rst_mark;
  bit  m_last;
  bit  e_ack0, e_ack1, e_busy, e_ov;

  wire  [7:0] act = {ack0, ack1, busy, out_valid, delay};
  logic [7:0] exp_v;

  task automatic model_reset();
    m_delay     = 0;
    m_last      = 1'b1;
    m_busy_last = -1;
    rst_mark    = cyc;
    e_ack0      = 1'b0;
    e_ack1      = 1'b0;
    e_busy      = 1'b0;
    e_ov        = 1'b0;
    exp_v       = {4'b0000, 4'(m_delay)};
  endtask

  // One clock: sample inputs, step the model at the edge, settle 1 time unit.
  task automatic tick();
    bit s_v, s_r0, s_r1, s_rst;
    int s_d0, s_d1, w, nd, idx;
    s_v = in_valid; s_r0 = req0; s_r1 = req1; s_rst = rst_n;
    s_d0 = int'(req0_delay); s_d1 = int'(req1_delay);
    @(posedge clk);
    cyc++;
    if (!s_rst) begin
      model_reset();
      vin[cyc] = 1'b0;
    end else begin
      vin[cyc] = s_v;
      e_ack0 = 1'b0;
      e_ack1 = 1'b0;
      // Grant only if the cycle before this edge was idle.
      if ((cyc - 1 > m_busy_last) && (s_r0 || s_r1)) begin
        if (s_r0 && s_r1) w = m_last ? 0 : 1;
        else              w = s_r0 ? 0 : 1;
        nd = (w == 1) ? s_d1 : s_d0;
        if (w == 0) e_ack0 = 1'b1; else e_ack1 = 1'b1;
        m_last = (w == 1);
        if (nd != m_delay) m_busy_last = cyc + nd;
        m_delay = nd;
      end
    end
    e_busy = (cyc <= m_busy_last);
    idx    = cyc - m_delay;
    e_ov   = !e_busy && (idx > rst_mark) && vin[idx];
    exp_v  = {e_ack0, e_ack1, e_busy, e_ov, 4'(m_delay)};
    #1;
    if (e_ack0) req0 = 1'b0;
    if (e_ack1) req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; req0 = 1'b0; req1 = 1'b0;
    req0_delay = 4'd0; req1_delay = 4'd0;
    #2;
    model_reset();
    total++;
    if (act !== exp_v) begin bad++; $display("FAIL reset_init got=%b exp=%b", act, exp_v); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, act, exp_v); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom);
      tick();
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, act, exp_v); end
    end
  endtask

  task automatic test_valid_align();
    int npulse = 0;
    int pos    = -1;
    in_valid = 1'b0; req0 = 1'b1; req0_delay = 4'd3;
    for (int i = 0; i < 24; i++) begin
      tick();
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL valid_align cyc=%0d got=%b exp=%b", cyc, act, exp_v); end
      if (out_valid === 1'b1) begin npulse++; pos = i; end
      in_valid = (i == 8);
    end
    total++;
    if (npulse != 1 || pos != 12) begin
      bad++; $display("FAIL valid_align_pulse got n=%0d at=%0d exp n=1 at=12", npulse, pos);
    end
  endtask

  task automatic test_single_change();
    int bcnt;
    int ackat;
    int vals [3] = '{5, 0, 15};
    for (int k = 0; k < 3; k++) begin
      bcnt = 0; ackat = -1;
      req0 = 1'b1; req0_delay = 4'(vals[k]);
      for (int i = 0; i < 22; i++) begin
        tick();
        total++;
        if (act !== exp_v) begin bad++; $display("FAIL single_change cyc=%0d got=%b exp=%b", cyc, act, exp_v); end
        if (busy === 1'b1) bcnt++;
        if (ack0 === 1'b1 && ackat < 0) ackat = i;
        in_valid = 1'($urandom);
      end
      total++;
      if (bcnt != vals[k] + 1 || ackat != 0) begin
        bad++; $display("FAIL settle_len val=%0d got busy=%0d ack_at=%0d exp busy=%0d ack_at=0", vals[k], bcnt, ackat, vals[k] + 1);
      end
    end
  endtask

  task automatic test_tie();
    int order [$];
    int ack1at = -1;
    #2 rst_n = 1'b0;
    #1 model_reset();
    tick();
    rst_n = 1'b1;
    req0 = 1'b1; req0_delay = 4'd2; req1 = 1'b1; req1_delay = 4'd7;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL tie cyc=%0d got=%b exp=%b", cyc, act, exp_v); end
      if (ack0 === 1'b1) order.push_back(0);
      if (ack1 === 1'b1) begin order.push_back(1); ack1at = i; end
      in_valid = 1'($urandom);
    end
    total++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 1 || ack1at != 4 || delay !== 4'd7) begin
      bad++; $display("FAIL tie_order got n=%0d ack1_at=%0d delay=%0d exp n=2 0,1 ack1_at=4 delay=7", order.size(), ack1at, delay);
    end
    order.delete();
    req0 = 1'b1; req0_delay = 4'd9; req1 = 1'b1; req1_delay = 4'd1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL tie_repeat cyc=%0d got=%b exp=%b", cyc, act, exp_v); end
      if (ack0 === 1'b1) order.push_back(0);
      if (ack1 === 1'b1) order.push_back(1);
    end
    total++;
    if (order.size() != 2 || order[0] != 0 || delay !== 4'd1) begin
      bad++; $display("FAIL tie_rr got n=%0d first=%0d delay=%0d exp n=2 first=0 delay=1", order.size(), (order.size() > 0) ? order[0] : -1, delay);
    end
  endtask

  task automatic test_same_value();
    int bcnt = 0;
    int acks = 0;
    int ovlow = 0;
    in_valid = 1'b1;
    req0 = 1'b1; req0_delay = 4'd4;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL same_setup cyc=%0d got=%b exp=%b", cyc, act, exp_v); end
    end
    req1 = 1'b1; req1_delay = 4'd4;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL same_value cyc=%0d got=%b exp=%b", cyc, act, exp_v); end
      if (busy === 1'b1) bcnt++;
      if (ack1 === 1'b1) acks++;
      if (out_valid !== 1'b1) ovlow++;
    end
    total++;
    if (bcnt != 0 || acks != 1 || ovlow != 0) begin
      bad++; $display("FAIL same_value_sum got busy=%0d ack1=%0d ov_low=%0d exp 0 1 0", bcnt, acks, ovlow);
    end
  endtask

  task automatic test_reset_settle();
    int first = -1;
    in_valid = 1'b1;
    req0 = 1'b1; req0_delay = 4'd15;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL rst_settle_pre cyc=%0d got=%b exp=%b", cyc, act, exp_v); end
    end
    #2 rst_n = 1'b0;
    #1 model_reset();
    total++;
    if (act !== exp_v) begin bad++; $display("FAIL rst_settle_async got=%b exp=%b", act, exp_v); end
    tick();
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL rst_settle_post cyc=%0d got=%b exp=%b", cyc, act, exp_v); end
      if (out_valid === 1'b1 && first < 0) first = i;
      in_valid = (i >= 1);
    end
    total++;
    if (first != 2) begin bad++; $display("FAIL rst_settle_first_valid got=%0d exp=2", first); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom);
      if (!req0 && ($urandom_range(0, 9) == 0)) begin req0 = 1'b1; req0_delay = 4'($urandom); end
      if (!req1 && ($urandom_range(0, 9) == 0)) begin req1 = 1'b1; req1_delay = 4'($urandom); end
      tick();
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, act, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_valid_align();
    test_single_change();
    test_tie();
    test_same_value();
    test_reset_settle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Controller for the SRL16E-based variable delay line.
- Arbitrates delay-change requests from two configuration requesters (round-robin), drives the 4-bit tap address, and generates a valid flag aligned to the delayed data.
- Blanks that valid flag while the line settles after a tap change.
- Sits beside delay_line; its delay output connects directly to the delay line's delay input, and its in_valid comes from the same source as din.

Parameters:
- DELAY_BITS, 4, tap address width; line depth = 2**DELAY_BITS (16 for SRL16E).
- RESET_DELAY, 0, tap address loaded on reset.
- SETTLE_EN, 1, 1 = blank out_valid for new_delay+1 cycles after a change; 0 = no blanking (SETTLE state skipped).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  qualifier for din entering the delay line this cycle
- req0  in  1  requester 0 asks for a delay change; held until ack0
- req0_delay  in  DELAY_BITS  requested tap address from requester 0
- ack0  out  1  one-cycle pulse: req0 accepted
- req1  in  1  requester 1 asks for a delay change; held until ack1
- req1_delay  in  DELAY_BITS  requested tap address from requester 1
- ack1  out  1  one-cycle pulse: req1 accepted
- delay  out  DELAY_BITS  tap address to delay line (registered)
- out_valid  out  1  dout of delay line is valid this cycle
- busy  out  1  controller in SETTLE; requests not accepted

Behaviour:
- Reset (async assert, sync deassert by user):
  - delay=RESET_DELAY; ack0=ack1=0; busy=0; out_valid=0.
  - State=IDLE; settle counter=0; valid shift register vsr all 0.
  - Round-robin pointer = "last grant 1", so requester 0 wins the first tie.
- Data latency: delay line output = din delayed delay+1 cycles.
  - vsr is a 2**DELAY_BITS-bit shift register; vsr[0] <= in_valid every cycle, vsr[k] <= vsr[k-1].
  - vsr shifts in every state, including SETTLE.
  - out_valid = vsr[delay] AND (state==IDLE), combinational from registers.
- States: IDLE, SETTLE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, it is granted. If both are high, the requester not granted last wins; the pointer updates on every grant.
  - Grant in cycle T: at edge T+1, ack<n>=1 for exactly one cycle and delay<=req<n>_delay.
  - If the new value != current delay and SETTLE_EN=1: state<=SETTLE, counter<=new value.
  - If the new value == current delay, or SETTLE_EN=0: ack only; stay IDLE; no blanking.
- SETTLE:
  - busy=1; out_valid forced 0; reqs ignored and stay pending.
  - Counter decrements each cycle. When counter==0: state<=IDLE, busy<=0.
  - SETTLE therefore lasts new_delay+1 cycles. A grant can occur on the first IDLE cycle after SETTLE.
- Boundary cases:
  - Requester drops req before ack: no grant; the request is lost (protocol violation, not checked).
  - Requester holds req after ack: the cycle after ack is treated as a new request, so requesters must deassert on ack.
  - New value 0: SETTLE is 1 cycle.
  - New value 15: SETTLE is 16 cycles.
  - Counter width = DELAY_BITS; no wrap, because it loads at most 2**DELAY_BITS-1.
  - Reset mid-SETTLE: immediate return to reset values; the pending change is discarded (delay=RESET_DELAY).
- ack0 and ack1 are never high in the same cycle.

Decomposition:
- Shared package delay_pkg:
  - DELAY_BITS default constant.
  - State encoding constants ST_IDLE=1'b0, ST_SETTLE=1'b1.
- One natural sub-module: rr_arb2 (2-input round-robin arbiter).
  - Inputs: req[1:0], grant_en.
  - Outputs: one-hot gnt[1:0].
  - Pointer register inside, reset to "last=1".
- The valid shift register and FSM stay in delay_line_ctrl.

Test Plan:
- Reset values: assert rst_n=0 mid-cycle -> delay=0, out_valid=0, busy=0 immediately (async); ack0=ack1=0.
- Valid alignment: delay=3, in_valid pulse at cycle 10 -> out_valid high at cycle 14 only (delay+1=4 cycles).
- Single change: req0=1, req0_delay=5 at cycle T -> ack0 pulse at T+1, delay=5 at T+1, busy/blanking for 6 cycles (T+1..T+6), out_valid follows vsr[5] from T+7.
- Tie and round-robin: after reset, req0 and req1 both high with delays 2 and 7 -> ack0 first; once SETTLE ends, ack1 on the next IDLE cycle; delay ends at 7. Repeat with both high -> ack0 (pointer alternates).
- Same-value request: delay=4, req1 with 4 -> ack1 pulse, busy stays 0, out_valid uninterrupted for continuous in_valid.
- Reset during SETTLE: request delay 15, assert rst_n=0 at SETTLE cycle 3 -> delay returns to RESET_DELAY, busy=0. After release, vsr is empty, so out_valid stays 0 until in_valid has propagated (RESET_DELAY+1 cycles).
